// File: rtl/uart_tx_serial.sv
// uart_tx_serial: byte-to-serial UART transmitter, 8N1/8N2 frames, 8E1/8E2 with parity.
// Define UART_TX_PARITY_EN to compile in the even-parity bit after the data bits.
module uart_tx_serial #(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned BAUD_RATE    = 115200,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_en,
   input  logic [7:0] uart_din,
   output logic       uart_tx_busy,
   output logic       uart_txd
);

   localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned StopW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
   localparam logic [CntW-1:0]  CntReload = CntW'(CLKS_PER_BIT - 1);
   localparam logic [StopW-1:0] StopLast  = StopW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [StopW-1:0] stop_q, stop_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end = (cnt_q == '0);

      // Bit timer runs in every non-idle state; each bit end reloads it.
      if (state_q != StIdle) begin
         cnt_d = bit_end ? CntReload : cnt_q - 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (uart_en) begin
               shreg_d = uart_din;
               cnt_d   = CntReload;
               state_d = StStart;
`ifdef UART_TX_PARITY_EN
               parity_d = ^uart_din;
`endif
            end
         end
         StStart: begin
            if (bit_end) begin
               idx_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (idx_q == 3'd7) begin
                  idx_d  = 3'd0;
                  stop_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               stop_d  = '0;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               if (stop_q == StopLast) begin
                  stop_d  = '0;
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Line level is decoded from the next state so txd and busy are both registered.
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != StIdle);
      unique case (state_d)
         StIdle:   txd_d = 1'b1;
         StStart:  txd_d = 1'b0;
         StData:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: txd_d = parity_q;
`endif
         StStop:   txd_d = 1'b1;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         stop_q   <= '0;
         shreg_q  <= 8'h00;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         stop_q   <= stop_d;
         shreg_q  <= shreg_d;
         txd_q    <= txd_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign uart_txd     = txd_q;
   assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_serial.sv
// Bench for uart_tx_serial: directed and random byte stimulus against a frame-level model.
// Two DUTs (STOP_BITS=1 and 2) share stimulus; each has its own expected-frame queue.
`timescale 1ns/1ps
module tb_uart_tx_serial;

   localparam int unsigned N = 16;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned P = 1;
`else
   localparam int unsigned P = 0;
`endif

   typedef struct packed {
      logic [31:0] c;  // posedge index at which the frame was accepted
      logic [7:0]  b;
   } frame_t;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       uart_en   = 1'b0;
   logic [7:0] uart_din  = 8'h00;
   logic [1:0] busy;
   logic [1:0] txd;

   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   frame_t      q0[$];
   frame_t      q1[$];
   int unsigned next_ok   [2];
   int unsigned frame_len [2];
   logic        mon_active [2];
   frame_t      mon_cur    [2];

   uart_tx_serial #(.CLK_FREQ(1600), .BAUD_RATE(100), .STOP_BITS(1)) u_dut1 (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .uart_en      (uart_en),
      .uart_din     (uart_din),
      .uart_tx_busy (busy[0]),
      .uart_txd     (txd[0])
   );

   uart_tx_serial #(.CLK_FREQ(1600), .BAUD_RATE(100), .STOP_BITS(2)) u_dut2 (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .uart_en      (uart_en),
      .uart_din     (uart_din),
      .uart_tx_busy (busy[1]),
      .uart_txd     (txd[1])
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int k, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %0d want %0d", name, k, cyc, act, exp);
      end
   endtask

   // Expected line level at offset o (cycles) into a frame carrying byte b.
   function automatic logic exp_bit(input int unsigned o, input logic [7:0] b);
      int unsigned j;
      j = o / N;
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (P == 1 && j == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic mon_step(input int k);
      frame_t h;
      logic   have;
      int unsigned o;
      if (!sys_rst_n) begin
         mon_active[k] = 1'b0;
         if (k == 0) q0.delete(); else q1.delete();
         chk("reset_txd", k, txd[k], 1);
         chk("reset_busy", k, busy[k], 0);
         return;
      end
      have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      h = '0;
      if (have) h = (k == 0) ? q0[0] : q1[0];
      if (!mon_active[k]) begin
         if (busy[k]) begin
            if (!have) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_frame dut%0d cyc %0d: busy=1 want no frame", k, cyc);
            end else begin
               if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               chk("start_time", k, cyc, h.c);
               mon_active[k] = 1'b1;
               mon_cur[k]    = h;
            end
         end else begin
            if (have && h.c <= cyc) begin
               n_tests++;
               n_fail++;
               $display("FAIL missing_frame dut%0d cyc %0d: busy=0 want frame 0x%02h", k, cyc, h.b);
               if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            chk("idle_txd", k, txd[k], 1);
         end
      end
      if (mon_active[k]) begin
         o = cyc - mon_cur[k].c;
         if (o < frame_len[k]) begin
            chk("frame_busy", k, busy[k], 1);
            chk("frame_txd", k, txd[k], exp_bit(o, mon_cur[k].b));
         end else begin
            chk("busy_fall", k, busy[k], 0);
            chk("end_txd", k, txd[k], 1);
            mon_active[k] = 1'b0;
         end
      end
   endtask

   always @(negedge sys_clk) begin
      mon_step(0);
      mon_step(1);
   end

   // Drive one cycle starting at a negedge; the model decides acceptance per DUT.
   task automatic drive_cycle(input logic en, input logic [7:0] d);
      frame_t f;
      uart_en  = en;
      uart_din = d;
      if (en && sys_rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (cyc + 1 >= next_ok[k]) begin
               f.c = cyc + 1;
               f.b = d;
               if (k == 0) q0.push_back(f); else q1.push_back(f);
               next_ok[k] = cyc + 1 + frame_len[k] + 1;
            end
         end
      end
      @(negedge sys_clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(1'b0, 8'($urandom));
   endtask

   task automatic wait_done();
      while (cyc + 1 < next_ok[0] || cyc + 1 < next_ok[1]) drive_cycle(1'b0, 8'($urandom));
      idle(2);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_len[0] = (1 + 8 + P + 1) * N;
      frame_len[1] = (1 + 8 + P + 2) * N;
      next_ok[0] = 0;
      next_ok[1] = 0;
      mon_active[0] = 1'b0;
      mon_active[1] = 1'b0;
      @(negedge sys_clk);

      // Reset held, with a start request that must be dropped.
      idle(3);
      drive_cycle(1'b1, 8'hAA);
      idle(2);
      sys_rst_n = 1'b1;
      idle(3);

      drive_cycle(1'b1, 8'h55);
      wait_done();
      drive_cycle(1'b1, 8'h07);
      wait_done();

      // Back-to-back: second request in the first idle cycle of DUT1.
      drive_cycle(1'b1, 8'hA5);
      while (cyc + 1 < next_ok[0]) drive_cycle(1'b0, 8'h00);
      drive_cycle(1'b1, 8'h3C);
      wait_done();

      // Request mid-frame is ignored.
      drive_cycle(1'b1, 8'h00);
      idle(40);
      drive_cycle(1'b1, 8'hFF);
      wait_done();

      // Asynchronous reset 50 cycles into a frame.
      drive_cycle(1'b1, 8'h5A);
      idle(49);
      #2;
      sys_rst_n = 1'b0;
      next_ok[0] = 0;
      next_ok[1] = 0;
      #1;
      chk("async_txd", 0, txd[0], 1);
      chk("async_busy", 0, busy[0], 0);
      chk("async_txd", 1, txd[1], 1);
      chk("async_busy", 1, busy[1], 0);
      @(negedge sys_clk);
      idle(2);
      sys_rst_n = 1'b1;
      idle(3);
      drive_cycle(1'b1, 8'h81);
      wait_done();

      // uart_en held across a whole frame restarts when busy drops.
      repeat (frame_len[0] + 5) drive_cycle(1'b1, 8'hC3);
      wait_done();

      // Random traffic: mixed gaps, held requests and exact back-to-back starts.
      for (int i = 0; i < 30; i++) begin
         int unsigned len;
         len = $urandom_range(1, 3);
         for (int j = 0; j < int'(len); j++) drive_cycle(1'b1, 8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            while (cyc + 1 < next_ok[0]) drive_cycle(1'b0, 8'($urandom));
         end else begin
            idle($urandom_range(0, 220));
         end
      end
      wait_done();
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
